instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter START_ADDR, default 8'd10: fetch address loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 endereco  output  8  address to the instruction memory, driven directly from the fetch_pc register.
REQ-005 instrucao  input  8  memory word for endereco; memory updates it on negedge, so it is valid at the next posedge.
REQ-006 desvio  input  1  redirect request (branch/jump taken), sampled on posedge.
REQ-007 alvo  input  8  redirect target address, qualified by desvio.
REQ-008 inst_valid  output  1  head entry of the prefetch buffer is valid.
REQ-009 inst_ready  input  1  consumer accepts the head entry.
REQ-010 inst_out  output  8  instruction word of the head entry.
REQ-011 pc_out  output  8  address of the head entry.

Function
REQ-012 The block SHALL hold a 2-entry in-order prefetch buffer of {pc, instruction} pairs; inst_out/pc_out/inst_valid SHALL come from the head entry, registered.
REQ-013 pop SHALL equal inst_valid && inst_ready; issue SHALL equal !desvio && (count < 2 || pop).
REQ-014 On a posedge with issue=1: push {fetch_pc, instrucao}; fetch_pc <= fetch_pc + 1.
REQ-015 On a posedge with issue=0 and desvio=0: fetch_pc and endereco SHALL hold; no push.
REQ-016 fetch_pc increment SHALL wrap modulo 256 (255 -> 0), with no flag or stall.
REQ-017 Push and pop on the same edge SHALL be legal at any count, including count=2; the count SHALL remain unchanged.
REQ-018 inst_out and pc_out SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-019 desvio=1 on a posedge SHALL:
  - flush both buffer entries (inst_valid=0 in the next cycle);
  - load fetch_pc <= alvo;
  - suppress that cycle's push.
REQ-020 desvio has priority over a simultaneous pop. The transfer on that edge counts as done for the consumer, and the remaining entries are still flushed.
REQ-021 Back-to-back desvio: each edge with desvio=1 SHALL reload fetch_pc; only the last alvo takes effect.
REQ-022 Latency: first inst_valid=1 SHALL appear in the second cycle after the edge that loaded fetch_pc, whether by reset release or desvio.
REQ-023 With inst_ready held at 1 and no desvio, throughput SHALL be one instruction per cycle.
REQ-024 Empty-buffer outputs: inst_out and pc_out SHALL retain their last values; consumers SHALL ignore them.

Reset
REQ-025 On a posedge with reset=1:
  - fetch_pc = START_ADDR; count = 0; inst_valid = 0;
  - inst_out = 8'h00; pc_out = 8'h00;
  - desvio and inst_ready are ignored.
REQ-026 Reset asserted mid-operation SHALL discard buffered and in-flight instructions; the next valid output SHALL be pc_out=START_ADDR.

Structure
REQ-027 Package instruction_fetch_pkg SHALL hold ADDR_W=8, INST_W=8, FETCH_DEPTH=2, and the packed fetch_entry_t {pc, inst} typedef.
REQ-028 The buffer SHALL be the sub-module fetch_buffer: 2-entry FIFO with push, pop, flush, count, and head outputs. fetch_pc and issue logic stay in instruction_fetch.

Verification (memory model reads on negedge; MEMI[10]=0x08, [11]=0x10, [12]=0x17, [56]=0x8C)
REQ-029 Release reset, inst_ready=1 -> (pc_out, inst_out) = (10,0x08), (11,0x10), (12,0x17) on consecutive cycles; first valid in the 2nd cycle after the release edge.
REQ-030 Release reset, inst_ready=0 for 5 cycles -> count=2, endereco holds 12, head stays (10,0x08). Then inst_ready=1 -> 10, 11, 12 in order, no duplicates or gaps.
REQ-031 With 2 entries buffered, desvio=1, alvo=56 for one cycle -> inst_valid=0 next cycle; then (56,0x8C) two cycles after the desvio edge.
REQ-032 START_ADDR=254, inst_ready=1 -> pc_out sequence 254, 255, 0, 1.
REQ-033 desvio=1 on the same edge as a pop with count=2 -> both entries dropped; no stale entry appears after alvo's instruction.
REQ-034 reset=1 for one cycle while streaming -> inst_valid=0 and endereco=10 next cycle; then (10,0x08) resumes per REQ-029.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared widths, buffer depth and the prefetch entry type for the instruction
// fetch unit.
package instruction_fetch_pkg;

    localparam int ADDR_W      = 8;
    localparam int INST_W      = 8;
    localparam int FETCH_DEPTH = 2;
    localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps 255 -> 0 with no flag.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order prefetch FIFO. The head entry and its valid flag are
// registers, so they can feed the consumer directly.
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fetch_entry_t     head_entry
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FETCH_DEPTH);

    fetch_entry_t     entry0_q, entry0_d;
    fetch_entry_t     entry1_q, entry1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    // Next-state of the FIFO: a flush keeps the head data but empties the buffer.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush) begin
            count_d = CNT_ZERO;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == CNT_ZERO) begin
                        entry0_d = push_entry;
                        count_d  = CNT_ONE;
                    end else if (count_q == CNT_ONE) begin
                        entry1_d = push_entry;
                        count_d  = CNT_FULL;
                    end else begin
                        count_d = count_q;
                    end
                end
                2'b01: begin
                    if (count_q == CNT_FULL) begin
                        entry0_d = entry1_q;
                        count_d  = CNT_ONE;
                    end else if (count_q == CNT_ONE) begin
                        count_d = CNT_ZERO;
                    end else begin
                        count_d = count_q;
                    end
                end
                2'b11: begin
                    if (count_q == CNT_FULL) begin
                        entry0_d = entry1_q;
                        entry1_d = push_entry;
                    end else if (count_q == CNT_ONE) begin
                        entry0_d = push_entry;
                    end else begin
                        entry0_d = push_entry;
                        count_d  = CNT_ONE;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        valid_d = (count_d != CNT_ZERO);
    end

    // FIFO state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry0_q <= fetch_entry_t'('0);
            entry1_q <= fetch_entry_t'('0);
            count_q  <= CNT_ZERO;
            valid_q  <= 1'b0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign count      = count_q;
    assign head_valid = valid_q;
    assign head_entry = entry0_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: fetch address register, issue/redirect control
// and a two-entry prefetch buffer presenting {pc, instruction} to the consumer.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = 8'd10
)
(
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] endereco,
    input  logic [INST_W-1:0] instrucao,
    input  logic              desvio,
    input  logic [ADDR_W-1:0] alvo,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FETCH_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count_s;
    logic              head_valid_s;
    fetch_entry_t      head_entry_s;
    fetch_entry_t      push_entry_s;
    logic              pop_s;
    logic              issue_s;

    assign pop_s   = head_valid_s && inst_ready;
    assign issue_s = !desvio && ((count_s < CNT_FULL) || pop_s);

    assign push_entry_s.pc   = fetch_pc_q;
    assign push_entry_s.inst = instrucao;

    // A redirect overrides sequential fetch; otherwise advance only on issue.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (desvio) begin
            fetch_pc_d = alvo;
        end else if (issue_s) begin
            fetch_pc_d = pc_incr(fetch_pc_q);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Fetch address register.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= START_ADDR;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (issue_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (desvio),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_entry (head_entry_s)
    );

    assign endereco   = fetch_pc_q;
    assign inst_valid = head_valid_s;
    assign inst_out   = head_entry_s.inst;
    assign pc_out     = head_entry_s.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (start 10 and start 254) share
// stimulus and are compared every cycle against a list-based reference model.
module tb_instruction_fetch;

    logic       clock;
    logic       reset;
    logic       desvio;
    logic [7:0] alvo;
    logic       inst_ready;

    logic [7:0] endereco_a, instrucao_a, inst_out_a, pc_out_a;
    logic       inst_valid_a;
    logic [7:0] endereco_b, instrucao_b, inst_out_b, pc_out_b;
    logic       inst_valid_b;

    logic [7:0] mem [256];

    int tests_run;
    int tests_failed;

    // Reference model state per instance: ordered entry list plus fetch pointer.
    int m_n     [2];
    int m_pc    [2][2];
    int m_inst  [2][2];
    int m_fetch [2];
    int m_hpc   [2];
    int m_hinst [2];
    int start_addr [2];

    instruction_fetch #(.START_ADDR(8'd10)) u_dut_a (
        .clock (clock), .reset (reset), .endereco (endereco_a), .instrucao (instrucao_a),
        .desvio (desvio), .alvo (alvo), .inst_valid (inst_valid_a), .inst_ready (inst_ready),
        .inst_out (inst_out_a), .pc_out (pc_out_a)
    );

    instruction_fetch #(.START_ADDR(8'd254)) u_dut_b (
        .clock (clock), .reset (reset), .endereco (endereco_b), .instrucao (instrucao_b),
        .desvio (desvio), .alvo (alvo), .inst_valid (inst_valid_b), .inst_ready (inst_ready),
        .inst_out (inst_out_b), .pc_out (pc_out_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction memory: word for the presented address changes on negedge.
    always @(negedge clock) begin
        instrucao_a <= mem[endereco_a];
        instrucao_b <= mem[endereco_b];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int k, input bit rst, input bit dsv, input int tgt, input bit rdy);
        bit popped;
        if (rst) begin
            m_n[k]     = 0;
            m_fetch[k] = start_addr[k];
            m_hpc[k]   = 0;
            m_hinst[k] = 0;
        end else begin
            popped = (m_n[k] > 0) && rdy;
            if (dsv) begin
                m_n[k]     = 0;
                m_fetch[k] = tgt;
            end else begin
                if (popped) begin
                    m_pc[k][0]   = m_pc[k][1];
                    m_inst[k][0] = m_inst[k][1];
                    m_n[k]--;
                end
                if (m_n[k] < 2) begin
                    m_pc[k][m_n[k]]   = m_fetch[k];
                    m_inst[k][m_n[k]] = int'(mem[m_fetch[k]]);
                    m_n[k]++;
                    m_fetch[k] = (m_fetch[k] + 1) % 256;
                end
            end
            if (m_n[k] > 0) begin
                m_hpc[k]   = m_pc[k][0];
                m_hinst[k] = m_inst[k][0];
            end
        end
    endtask

    task automatic check_all();
        check_val("a_valid", 32'(inst_valid_a), 32'(m_n[0] > 0));
        check_val("a_pc",    32'(pc_out_a),     32'(m_hpc[0]));
        check_val("a_inst",  32'(inst_out_a),   32'(m_hinst[0]));
        check_val("a_addr",  32'(endereco_a),   32'(m_fetch[0]));
        check_val("b_valid", 32'(inst_valid_b), 32'(m_n[1] > 0));
        check_val("b_pc",    32'(pc_out_b),     32'(m_hpc[1]));
        check_val("b_inst",  32'(inst_out_b),   32'(m_hinst[1]));
        check_val("b_addr",  32'(endereco_b),   32'(m_fetch[1]));
    endtask

    // One clock: drive on negedge, model the posedge, compare 1 time unit later.
    task automatic step(input bit rst, input bit dsv, input logic [7:0] tgt, input bit rdy);
        @(negedge clock);
        reset      = rst;
        desvio     = dsv;
        alvo       = tgt;
        inst_ready = rdy;
        @(posedge clock);
        model_edge(0, rst, dsv, int'(tgt), rdy);
        model_edge(1, rst, dsv, int'(tgt), rdy);
        #1;
        check_all();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start_addr[0] = 10;
        start_addr[1] = 254;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[10] = 8'h08;
        mem[11] = 8'h10;
        mem[12] = 8'h17;
        mem[56] = 8'h8C;
        reset = 1'b1; desvio = 1'b0; alvo = 8'd0; inst_ready = 1'b1;

        // Reset state, then streaming with ready held high.
        step(1'b1, 1'b0, 8'd0, 1'b1);
        step(1'b1, 1'b1, 8'd77, 1'b1);
        check_val("rst_valid", 32'(inst_valid_a), 32'd0);
        check_val("rst_addr",  32'(endereco_a),   32'd10);
        check_val("rst_pc",    32'(pc_out_a),     32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("s1_pc",   32'(pc_out_a),  32'd10);
        check_val("s1_inst", 32'(inst_out_a), 32'h08);
        check_val("w1_pc",   32'(pc_out_b),  32'd254);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("s2_inst", 32'(inst_out_a), 32'h10);
        check_val("w2_pc",   32'(pc_out_b),  32'd255);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("s3_inst", 32'(inst_out_a), 32'h17);
        check_val("w3_pc",   32'(pc_out_b),  32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("w4_pc",   32'(pc_out_b),  32'd1);

        // Back-pressure: buffer fills, fetch address holds.
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'd0, 1'b0);
        check_val("bp_addr", 32'(endereco_a), 32'd12);
        check_val("bp_pc",   32'(pc_out_a),   32'd10);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 1'b1);

        // Redirect with a full buffer, without and with a simultaneous pop.
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 8'd56, 1'b0);
        check_val("dv_flush", 32'(inst_valid_a), 32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        check_val("dv_pc",   32'(pc_out_a),   32'd56);
        check_val("dv_inst", 32'(inst_out_a), 32'h8C);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 8'd56, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("dvp_pc", 32'(pc_out_a), 32'd56);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("dvp_next", 32'(pc_out_a), 32'd57);

        // Back-to-back redirects: last target wins.
        step(1'b0, 1'b1, 8'd20, 1'b1);
        step(1'b0, 1'b1, 8'd56, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("b2b_pc", 32'(pc_out_a), 32'd56);

        // Reset pulse mid-stream.
        step(1'b1, 1'b0, 8'd0, 1'b1);
        check_val("mr_valid", 32'(inst_valid_a), 32'd0);
        check_val("mr_addr",  32'(endereco_a),   32'd10);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check_val("mr_pc",   32'(pc_out_a),   32'd10);
        check_val("mr_inst", 32'(inst_out_a), 32'h08);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 8'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
